release_req_queue: RTL
======================

Name: release_req_queue

Overview:
- Buffers writeback/release requests from the DCache eviction and probe paths and feeds them in FIFO order, one at a time, to the single-entry release unit.
- Holds an entry until the release unit pulses its finish output, which signals that the ReleaseAck grant has been received or that the release was fire-and-forget.
- Exposes an address-match query so the miss path can block a refill to a line that is still being written back.

Parameters:
- ENTRIES, 4, queue depth; power of two, at least 2.
- ADDR_W, 36, physical address width.
- DATA_W, 512, cache-line data width.
- OFFSET_W, 6, line-offset bits ignored in address compares (64 B line).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- io_enq_ready  out  1  queue can accept a request.
- io_enq_valid  in  1  request from DCache writeback path.
- io_enq_bits_addr  in  ADDR_W  line address.
- io_enq_bits_param  in  3  TileLink shrink/report param.
- io_enq_bits_voluntary  in  1  1 = Release, 0 = ProbeAck.
- io_enq_bits_hasData  in  1  carries data.
- io_enq_bits_dirty  in  1  line dirty.
- io_enq_bits_data  in  DATA_W  line data.
- io_deq_ready  in  1  release unit accepts (its io_req_ready).
- io_deq_valid  out  1  head request offered.
- io_deq_bits_*  out  same fields and widths as io_enq_bits_*.
- io_finish  in  1  one-cycle pulse from release unit: in-flight request complete.
- io_block_addr  in  ADDR_W  miss-path query address.
- io_block_hit  out  1  query matches any occupied entry.
- io_count  out  clog2(ENTRIES+1)  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Circular buffer of ENTRIES slots with head and tail pointers, log2(ENTRIES) bits each; both wrap modulo ENTRIES.
  - Occupancy count ranges 0..ENTRIES.
  - Every slot keeps a valid bit.
  - A single in_flight flag marks that the head entry has been handed to the release unit.
- Reset (asynchronous assert, synchronous-release tolerant):
  - head = tail = 0, count = 0, all valid = 0, in_flight = 0.
  - Outputs at reset: io_enq_ready = 1, io_deq_valid = 0, io_block_hit = 0, io_count = 0.
  - Data registers are not reset.
- Enqueue:
  - Fires when io_enq_valid & io_enq_ready, with io_enq_ready = (count != ENTRIES).
  - Writes the tail slot, sets its valid bit, tail++.
  - There is no bypass: the earliest io_deq_valid is the cycle after the enqueue.
- Dequeue state machine:
  - IDLE: io_deq_valid = valid[head] & !in_flight. A deq fire (valid & ready) sets in_flight and moves to WAIT_FINISH. The head entry stays occupied.
  - WAIT_FINISH: io_deq_valid = 0. On io_finish: clear valid[head], head++, count--, clear in_flight, return to IDLE.
  - The next entry is offered the cycle after finish, so there is a minimum 1-cycle gap.
  - io_finish while in IDLE is ignored and flagged by an assertion.
- io_deq_bits always reflect the head slot contents.
- Simultaneous enqueue and finish in the same cycle: both take effect; count is unchanged.
- When full, the queue does not accept an enqueue in the same cycle as a finish, because io_enq_ready depends on registered count only.
- Block query (combinational):
  - io_block_hit = OR over slots of valid[i] & (addr[i][ADDR_W-1:OFFSET_W] == io_block_addr[ADDR_W-1:OFFSET_W]).
  - The in-flight entry counts, since it stays valid until finish.
  - A slot being enqueued in the current cycle does not count; it counts from the next cycle.
- Ordering: strict FIFO. Duplicate line addresses are accepted and kept in order; no merging.
- Reset asserted mid-operation: all state clears immediately; in-flight context is lost. The release unit is reset by the same signal.

Decomposition:
- Shared package (release_pkg):
  - Request struct typedef: addr, param, voluntary, hasData, dirty, data.
  - Constants: ADDR_W, DATA_W, OFFSET_W, and the TileLink param encodings (TtoN, BtoN, NtoN, ...).
- Sub-module release_req_slot: one storage entry holding valid plus the request struct, with its line-address compare output. It is instantiated ENTRIES times.
- The top level holds the pointers, count, in_flight and the output muxing.

Test Plan:
- Single request:
  - Stimulus: enqueue addr=0x8_0000_0040, hasData=1, dirty=1; hold deq_ready=1.
  - Response: deq_valid rises 1 cycle later with identical bits; it drops after the fire; count stays 1 until finish; count=0 the cycle after finish.
- Fill and stall:
  - Stimulus: enqueue 4 requests with deq_ready=0.
  - Response: count=4, enq_ready=0; a 5th enq_valid is not accepted.
  - Then: deq, then finish. Response: count=3, enq_ready=1 the next cycle.
- FIFO order and wrap:
  - Stimulus: stream 10 requests with addrs 0x1000 + 0x40*k, finishing each 3 cycles after its deq fire.
  - Response: dequeue order k = 0..9; pointers wrap twice with no loss.
- Block hit:
  - Stimulus: enqueue addr 0x2040, then query 0x207F.
  - Response: io_block_hit=1 while queued and while in flight. It is 0 the cycle after finish; query 0x2080 always gives 0.
- Simultaneous events:
  - Stimulus: count=2, in flight; enqueue and finish in the same cycle.
  - Response: count stays 2; the next head is offered the following cycle.
- Async reset:
  - Stimulus: assert reset in WAIT_FINISH with count=3.
  - Response: outputs go immediately to enq_ready=1, deq_valid=0, count=0, block_hit=0; a later finish pulse is ignored.

Source files
------------

// File: rtl/release_pkg.sv
// Shared definitions for the release request queue.
//   - Physical address, line data and line-offset widths.
//   - TileLink shrink/report param encodings carried with each request.
//   - Request record stored per queue slot.
//   - Dequeue-side state encoding.
package release_pkg;

    localparam int ADDR_W   = 36;
    localparam int DATA_W   = 512;
    localparam int OFFSET_W = 6;

    // Shrink params (Release) followed by report params (ProbeAck).
    localparam logic [2:0] PARAM_TTOB = 3'd0;
    localparam logic [2:0] PARAM_TTON = 3'd1;
    localparam logic [2:0] PARAM_BTON = 3'd2;
    localparam logic [2:0] PARAM_TTOT = 3'd3;
    localparam logic [2:0] PARAM_BTOB = 3'd4;
    localparam logic [2:0] PARAM_NTON = 3'd5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        param;
        logic              voluntary;
        logic              hasData;
        logic              dirty;
        logic [DATA_W-1:0] data;
    } release_req_t;

    typedef enum logic {
        DEQ_IDLE,
        DEQ_WAIT_FINISH
    } deq_state_e;

endpackage

// File: rtl/release_req_slot.sv
// One storage entry of the release request queue.
//   clock, reset : clock and async active-low reset (clears valid only)
//   wr_en/wr_req : load the request and mark the slot occupied
//   clr_en       : release the slot once its writeback has finished
//   cmp_line     : line address (offset stripped) of the miss-path query
//   valid/req    : slot state and stored request
//   hit          : slot occupied and holding the queried line
module release_req_slot
    import release_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  release_req_t               wr_req,
    input  logic                       clr_en,
    input  logic [ADDR_W-OFFSET_W-1:0] cmp_line,
    output logic                       valid,
    output release_req_t               req,
    output logic                       hit
);

    // A write wins over a clear; the top never asks for both on one slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            valid <= 1'b0;
        else if (wr_en)
            valid <= 1'b1;
        else if (clr_en)
            valid <= 1'b0;
    end

    // Payload is qualified by valid, so it carries no reset.
    always_ff @(posedge clock) begin
        if (wr_en)
            req <= wr_req;
    end

    assign hit = valid & (req.addr[ADDR_W-1:OFFSET_W] == cmp_line);

endmodule

// File: rtl/release_req_queue.sv
// FIFO of writeback/release requests feeding the single-entry release unit.
//   clock, reset        : clock and async active-low reset
//   io_enq_*            : request from the DCache eviction/probe paths
//   io_deq_*            : head request offered to the release unit
//   io_finish           : release unit done with the in-flight head
//   io_block_addr/_hit  : miss-path query against every occupied slot
//   io_count            : number of occupied slots
// The head slot stays occupied while in flight so the block query keeps
// protecting the line until the release unit reports completion.
module release_req_queue #(
    parameter int ENTRIES  = 4,
    parameter int ADDR_W   = release_pkg::ADDR_W,
    parameter int DATA_W   = release_pkg::DATA_W,
    parameter int OFFSET_W = release_pkg::OFFSET_W
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         io_enq_ready,
    input  logic                         io_enq_valid,
    input  logic [ADDR_W-1:0]            io_enq_bits_addr,
    input  logic [2:0]                   io_enq_bits_param,
    input  logic                         io_enq_bits_voluntary,
    input  logic                         io_enq_bits_hasData,
    input  logic                         io_enq_bits_dirty,
    input  logic [DATA_W-1:0]            io_enq_bits_data,
    input  logic                         io_deq_ready,
    output logic                         io_deq_valid,
    output logic [ADDR_W-1:0]            io_deq_bits_addr,
    output logic [2:0]                   io_deq_bits_param,
    output logic                         io_deq_bits_voluntary,
    output logic                         io_deq_bits_hasData,
    output logic                         io_deq_bits_dirty,
    output logic [DATA_W-1:0]            io_deq_bits_data,
    input  logic                         io_finish,
    input  logic [ADDR_W-1:0]            io_block_addr,
    output logic                         io_block_hit,
    output logic [$clog2(ENTRIES+1)-1:0] io_count
);
    import release_pkg::*;

    localparam int PTR_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    deq_state_e         state, state_n;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;
    logic               in_flight;
    logic               enq_fire, deq_fire, fin_fire;
    logic [ENTRIES-1:0] slot_valid, slot_hit;
    release_req_t       slot_req [ENTRIES];
    release_req_t       enq_req, head_req;
    logic               unused_block_offset;

    assign enq_req = '{addr:      io_enq_bits_addr,
                       param:     io_enq_bits_param,
                       voluntary: io_enq_bits_voluntary,
                       hasData:   io_enq_bits_hasData,
                       dirty:     io_enq_bits_dirty,
                       data:      io_enq_bits_data};

    // Ready looks only at the registered count: a full queue cannot take a
    // new request in the cycle the head finishes.
    assign io_enq_ready = (count != CNT_W'(ENTRIES));
    assign enq_fire     = io_enq_valid & io_enq_ready;
    assign deq_fire     = io_deq_valid & io_deq_ready;

    // Dequeue FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= DEQ_IDLE;
        else
            state <= state_n;
    end

    // Dequeue FSM: next state
    always_comb begin
        state_n = state;
        case (state)
            DEQ_IDLE:        if (deq_fire)  state_n = DEQ_WAIT_FINISH;
            DEQ_WAIT_FINISH: if (io_finish) state_n = DEQ_IDLE;
            default:                        state_n = DEQ_IDLE;
        endcase
    end

    // Dequeue FSM: outputs. Finish outside WAIT_FINISH has no effect.
    always_comb begin
        in_flight    = (state == DEQ_WAIT_FINISH);
        io_deq_valid = slot_valid[head] & ~in_flight;
        fin_fire     = in_flight & io_finish;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) tail <= tail + PTR_W'(1);
            if (fin_fire) head <= head + PTR_W'(1);
            case ({enq_fire, fin_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
        release_req_slot u_slot (
            .clock    (clock),
            .reset    (reset),
            .wr_en    (enq_fire & (tail == PTR_W'(i))),
            .wr_req   (enq_req),
            .clr_en   (fin_fire & (head == PTR_W'(i))),
            .cmp_line (io_block_addr[ADDR_W-1:OFFSET_W]),
            .valid    (slot_valid[i]),
            .req      (slot_req[i]),
            .hit      (slot_hit[i])
        );
    end

    assign unused_block_offset = ^io_block_addr[OFFSET_W-1:0];

    assign head_req              = slot_req[head];
    assign io_deq_bits_addr      = head_req.addr;
    assign io_deq_bits_param     = head_req.param;
    assign io_deq_bits_voluntary = head_req.voluntary;
    assign io_deq_bits_hasData   = head_req.hasData;
    assign io_deq_bits_dirty     = head_req.dirty;
    assign io_deq_bits_data      = head_req.data;

    assign io_block_hit = |slot_hit;
    assign io_count     = count;

    a_finish_in_flight: assert property (@(posedge clock) disable iff (!reset)
        io_finish |-> in_flight);

endmodule
